// File: rtl/riscv_defines.sv
// Shared RV32 opcodes and the aligner halfword-offset state.
package riscv_defines;

  localparam logic [6:0] OPCODE_LOAD     = 7'h03;
  localparam logic [6:0] OPCODE_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPCODE_OPIMM    = 7'h13;
  localparam logic [6:0] OPCODE_STORE    = 7'h23;
  localparam logic [6:0] OPCODE_STORE_FP = 7'h27;
  localparam logic [6:0] OPCODE_OP       = 7'h33;
  localparam logic [6:0] OPCODE_LUI      = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
  localparam logic [6:0] OPCODE_JALR     = 7'h67;
  localparam logic [6:0] OPCODE_JAL      = 7'h6f;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;

  typedef enum logic {
    ALIGN_LO = 1'b0,
    ALIGN_HI = 1'b1
  } align_state_e;

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_compressed_decoder.sv
// Combinational RV32C to RV32 expander; 32-bit encodings pass through unchanged.
module riscv_compressed_decoder
  import riscv_defines::*;
#(
  parameter int unsigned FPU = 0
) (
  input  logic [31:0] raw,
  output logic [31:0] expanded,
  output logic        illegal
);

  localparam logic FPU_EN = (FPU != 0);

  logic [15:0] c;
  assign c = raw[15:0];

  always_comb begin
    expanded = raw;
    illegal  = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            expanded = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'h02, 3'b000, 2'b01, c[4:2], OPCODE_OPIMM};
            illegal  = (c[12:5] == 8'h00);
          end
          3'b001: begin
            expanded = {4'b0, c[6:5], c[12:10], 3'b000, 2'b01, c[9:7], 3'b011, 2'b01, c[4:2], OPCODE_LOAD_FP};
            illegal  = !FPU_EN;
          end
          3'b010, 3'b011: begin
            expanded = {5'b0, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2],
                        c[13] ? OPCODE_LOAD_FP : OPCODE_LOAD};
            illegal  = c[13] && !FPU_EN;
          end
          3'b101: begin
            expanded = {4'b0, c[6:5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b011, c[11:10], 3'b000, OPCODE_STORE_FP};
            illegal  = !FPU_EN;
          end
          3'b110, 3'b111: begin
            expanded = {5'b0, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, c[11:10], c[6], 2'b00,
                        c[13] ? OPCODE_STORE_FP : OPCODE_STORE};
            illegal  = c[13] && !FPU_EN;
          end
          default: illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: expanded = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b0, c[11:7], OPCODE_OPIMM};
          3'b001, 3'b101:
            expanded = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}}, 4'b0, ~c[15], OPCODE_JAL};
          3'b010: expanded = {{6{c[12]}}, c[12], c[6:2], 5'b0, 3'b0, c[11:7], OPCODE_OPIMM};
          3'b011: begin
            if (c[11:7] == 5'd2)
              expanded = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'h02, 3'b000, 5'h02, OPCODE_OPIMM};
            else
              expanded = {{15{c[12]}}, c[6:2], c[11:7], OPCODE_LUI};
            illegal = ({c[12], c[6:2]} == 6'b0);
          end
          3'b100: begin
            case (c[11:10])
              2'b00, 2'b01: begin
                expanded = {1'b0, c[10], 5'b0, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], OPCODE_OPIMM};
                illegal  = c[12];
              end
              2'b10: expanded = {{6{c[12]}}, c[12], c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], OPCODE_OPIMM};
              default: begin
                // SUB/XOR/OR/AND share a layout; only funct7 and funct3 differ
                expanded = {1'b0, (c[6:5] == 2'b00), 5'b0, 2'b01, c[4:2], 2'b01, c[9:7],
                            (c[6:5] == 2'b00) ? 3'b000 : {1'b1, c[6], c[5] & c[6]},
                            2'b01, c[9:7], OPCODE_OP};
                illegal  = c[12];
              end
            endcase
          end
          default:
            expanded = {{4{c[12]}}, c[6:5], c[2], 5'b0, 2'b01, c[9:7], 2'b00, c[13], c[11:10], c[4:3], c[12], OPCODE_BRANCH};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin
            expanded = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], OPCODE_OPIMM};
            illegal  = c[12];
          end
          3'b001: begin
            expanded = {3'b0, c[4:2], c[12], c[6:5], 3'b000, 5'h02, 3'b011, c[11:7], OPCODE_LOAD_FP};
            illegal  = !FPU_EN;
          end
          3'b010, 3'b011: begin
            expanded = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'h02, 3'b010, c[11:7],
                        c[13] ? OPCODE_LOAD_FP : OPCODE_LOAD};
            illegal  = c[13] ? !FPU_EN : (c[11:7] == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (c[6:2] != 5'd0) begin
                expanded = {7'b0, c[6:2], 5'b0, 3'b0, c[11:7], OPCODE_OP};
              end else begin
                expanded = {12'b0, c[11:7], 3'b0, 5'b0, OPCODE_JALR};
                illegal  = (c[11:7] == 5'd0);
              end
            end else if (c[6:2] != 5'd0) begin
              expanded = {7'b0, c[6:2], c[11:7], 3'b0, c[11:7], OPCODE_OP};
            end else if (c[11:7] == 5'd0) begin
              expanded = {12'h001, 13'b0, OPCODE_SYSTEM};
            end else begin
              expanded = {12'b0, c[11:7], 3'b0, 5'b00001, OPCODE_JALR};
            end
          end
          3'b101: begin
            expanded = {3'b0, c[9:7], c[12], c[6:2], 5'h02, 3'b011, c[11:10], 3'b000, OPCODE_STORE_FP};
            illegal  = !FPU_EN;
          end
          default: begin
            expanded = {4'b0, c[8:7], c[12], c[6:2], 5'h02, 3'b010, c[11:9], 2'b00,
                        c[13] ? OPCODE_STORE_FP : OPCODE_STORE};
            illegal  = c[13] && !FPU_EN;
          end
        endcase
      end
      default: begin
        expanded = raw;
        illegal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_instr_aligner.sv
// Fetch-word FIFO plus halfword realigner that emits expanded RV32 instructions with their PC.
module riscv_instr_aligner
  import riscv_defines::*;
#(
  parameter int unsigned FPU       = 0,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [31:0]              flush_addr_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [31:0]              fetch_rdata_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_instr_o,
  output logic [31:0]              out_pc_o,
  output logic                     out_is_compressed_o,
  output logic                     out_illegal_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  align_state_e  off, off_next;
  logic [31:0]   pc, pc_next;

  logic [31:0] head, next_word, exp_instr;
  logic [15:0] half;
  logic        compressed, exp_illegal, words_ok, handshake, push, pop;
  logic        unused_flush_lsb;

  assign unused_flush_lsb = flush_addr_i[0];
  assign head       = mem[rd_ptr];
  assign next_word  = mem[rd_ptr + PW'(1)];
  assign half       = (off == ALIGN_HI) ? head[31:16] : head[15:0];
  assign compressed = is_compressed(half);

  riscv_compressed_decoder #(.FPU(FPU)) u_decoder (
    .raw      ({16'b0, half}),
    .expanded (exp_instr),
    .illegal  (exp_illegal)
  );

  // Availability, instruction selection and next-state for pointers/offset/pc
  always_comb begin
    words_ok            = 1'b0;
    fetch_ready_o       = 1'b0;
    out_valid_o         = 1'b0;
    out_instr_o         = head;
    out_is_compressed_o = compressed;
    out_illegal_o       = 1'b0;
    handshake           = 1'b0;
    push                = 1'b0;
    pop                 = 1'b0;
    off_next            = off;
    pc_next             = pc;

    if (compressed || off == ALIGN_LO) words_ok = (count >= CW'(1));
    else                               words_ok = (count >= CW'(2));

    fetch_ready_o = rst_n && !flush_i && (count < CW'(DEPTH));
    out_valid_o   = rst_n && !flush_i && words_ok;

    if (compressed) begin
      out_instr_o   = exp_instr;
      out_illegal_o = exp_illegal;
    end else if (off == ALIGN_HI) begin
      out_instr_o = {next_word[15:0], head[31:16]};
    end

    handshake = out_valid_o && out_ready_i;
    push      = fetch_valid_i && fetch_ready_o;

    if (handshake) begin
      pop = !compressed || (off == ALIGN_HI);
      if (compressed) begin
        off_next = (off == ALIGN_LO) ? ALIGN_HI : ALIGN_LO;
        pc_next  = pc + 32'd2;
      end else begin
        pc_next  = pc + 32'd4;
      end
    end

    count_next = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      off    <= ALIGN_LO;
      pc     <= BOOT_ADDR;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      off    <= align_state_e'(flush_addr_i[1]);
      pc     <= {flush_addr_i[31:1], 1'b0};
    end else begin
      count <= count_next;
      off   <= off_next;
      pc    <= pc_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fetch_rdata_i;
  end

  assign out_pc_o    = pc;
  assign occupancy_o = count;

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Randomized bench: halfword-stream reference model plus directed alignment, backpressure and flush cases.
module tb_riscv_instr_aligner;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0080;
  localparam int          NTAB  = 12;

  logic        clk, rst_n, flush, fetch_valid, fetch_ready, out_valid, out_ready;
  logic [31:0] flush_addr, fetch_rdata, out_instr, out_pc;
  logic        out_is_c, out_ill;
  logic [2:0]  occupancy;

  riscv_instr_aligner #(.FPU(0), .DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush),
    .flush_addr_i        (flush_addr),
    .fetch_valid_i       (fetch_valid),
    .fetch_ready_o       (fetch_ready),
    .fetch_rdata_i       (fetch_rdata),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .out_instr_o         (out_instr),
    .out_pc_o            (out_pc),
    .out_is_compressed_o (out_is_c),
    .out_illegal_o       (out_ill),
    .occupancy_o         (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-expanded compressed encodings (FPU=0); the last three are illegal
  logic [15:0] tab_hw  [NTAB] = '{16'h4505, 16'h4585, 16'h852E, 16'h952E, 16'h157D, 16'h41C8,
                                  16'h050E, 16'h9002, 16'hA001, 16'h0000, 16'h6000, 16'h150E};
  logic [31:0] tab_exp [NTAB] = '{32'h00100513, 32'h00100593, 32'h00B00533, 32'h00B50533,
                                  32'hFFF50513, 32'h0045A503, 32'h00351513, 32'h00100073,
                                  32'h0000006F, 32'h0, 32'h0, 32'h0};
  logic        tab_ill [NTAB] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1};

  int checks, failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the stream of halfwords the program executes, plus its PC
  logic [15:0] mq[$];
  logic [31:0] mpc;
  logic        mskip;

  logic [31:0] seen_instr, seen_pc, seen_occ;
  logic        seen_valid, seen_ready, seen_c, seen_ill;

  function automatic int tab_find(input logic [15:0] h);
    for (int i = 0; i < NTAB; i++) if (tab_hw[i] == h) return i;
    return -1;
  endfunction

  task automatic step(input logic fv, input logic [31:0] word, input logic rdy,
                      input logic fl, input logic [31:0] faddr, output logic pushed);
    int occ, idx;
    logic ev, er, ec;
    @(negedge clk);
    fetch_valid = fv; fetch_rdata = word; out_ready = rdy; flush = fl; flush_addr = faddr;
    #1;
    seen_instr = out_instr; seen_pc = out_pc; seen_occ = 32'(occupancy);
    seen_valid = out_valid; seen_ready = fetch_ready; seen_c = out_is_c; seen_ill = out_ill;
    occ = (mq.size() + 1) / 2;
    er  = !fl && (occ < int'(DEPTH));
    ec  = (mq.size() > 0) && (mq[0][1:0] != 2'b11);
    ev  = !fl && (ec || (mq.size() >= 2 && mq[0][1:0] == 2'b11));
    check("fetch_ready", 32'(fetch_ready), 32'(er));
    check("out_valid", 32'(out_valid), 32'(ev));
    check("occupancy", 32'(occupancy), 32'(occ));
    if (ev) begin
      check("pc", out_pc, mpc);
      check("is_compressed", 32'(out_is_c), 32'(ec));
      if (ec) begin
        idx = tab_find(mq[0]);
        if (idx >= 0) begin
          check("illegal", 32'(out_ill), 32'(tab_ill[idx]));
          if (!tab_ill[idx]) check("instr_c", out_instr, tab_exp[idx]);
        end
      end else begin
        check("illegal", 32'(out_ill), 32'd0);
        check("instr", out_instr, {mq[1], mq[0]});
      end
    end
    pushed = fv && er;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mpc   = {faddr[31:1], 1'b0};
      mskip = faddr[1];
    end else begin
      if (ev && rdy) begin
        void'(mq.pop_front());
        if (ec) mpc = mpc + 32'd2;
        else begin void'(mq.pop_front()); mpc = mpc + 32'd4; end
      end
      if (pushed) begin
        if (!mskip) mq.push_back(word[15:0]);
        mq.push_back(word[31:16]);
        mskip = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0; fetch_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    repeat (cycles) begin
      #1;
      check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1; fetch_valid = 1'b0; out_ready = 1'b0;
    mq.delete(); mpc = BOOT; mskip = 1'b0;
  endtask

  // Program generator for the random phase
  logic [15:0] gen[$];
  logic        gen_skip;

  task automatic gen_instr();
    logic [31:0] w;
    if ($urandom_range(0, 1) == 0) begin
      gen.push_back(tab_hw[$urandom_range(0, NTAB - 1)]);
    end else begin
      w = $urandom;
      w[1:0] = 2'b11;
      gen.push_back(w[15:0]);
      gen.push_back(w[31:16]);
    end
  endtask

  task automatic build_word(output logic [31:0] w);
    if (gen_skip) begin
      while (gen.size() < 1) gen_instr();
      w = {gen.pop_front(), 16'($urandom)};
      gen_skip = 1'b0;
    end else begin
      while (gen.size() < 2) gen_instr();
      w[15:0]  = gen.pop_front();
      w[31:16] = gen.pop_front();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p, have_word, fl, fv, rdy;
    logic [31:0] cur_word, fa;
    checks = 0; failures = 0;
    rst_n = 1'b0; flush = 1'b0; flush_addr = '0; fetch_valid = 1'b0; fetch_rdata = '0; out_ready = 1'b0;
    mq.delete(); mpc = BOOT; mskip = 1'b0;

    do_reset(2);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, p);
    check("reset_ready", 32'(seen_ready), 32'd1);

    // Aligned 32-bit instruction after flush
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, p);
    step(1'b1, 32'h00A00593, 1'b0, 1'b0, 32'h0, p);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, p);
    check("d28_instr", seen_instr, 32'h00A00593);
    check("d28_pc", seen_pc, 32'h100);
    check("d28_c", 32'(seen_c), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);

    // Two compressed instructions in one word
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, p);
    step(1'b1, 32'h45854505, 1'b1, 1'b0, 32'h0, p);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);
    check("d29_instr0", seen_instr, 32'h00100513);
    check("d29_pc0", seen_pc, 32'h100);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);
    check("d29_instr1", seen_instr, 32'h00100593);
    check("d29_pc1", seen_pc, 32'h102);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);
    check("d29_occ", seen_occ, 32'd0);

    // 32-bit instruction straddling two words
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h202, p);
    step(1'b1, 32'h05930000, 1'b0, 1'b0, 32'h0, p);
    step(1'b1, 32'h000000A0, 1'b0, 1'b0, 32'h0, p);
    check("d30_novalid", 32'(seen_valid), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);
    check("d30_instr", seen_instr, 32'h00A00593);
    check("d30_pc", seen_pc, 32'h202);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, p);
    check("d30_next_pc", seen_pc, 32'h206);
    check("d30_next_c", 32'(seen_c), 32'd1);
    check("d30_occ", seen_occ, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);

    // Backpressure: FIFO fills, fifth word is held off
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, p);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h13 | (32'(i + 1) << 7), 1'b0, 1'b0, 32'h0, p);
      if (i > 0) check("d31_stable", seen_instr, 32'h00000093);
    end
    check("d31_ready", 32'(seen_ready), 32'd0);
    check("d31_occ", seen_occ, 32'd4);
    check("d31_held", 32'(p), 32'd0);
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);

    // Flush with a simultaneous push on a full FIFO
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h600, p);
    repeat (4) step(1'b1, 32'h00A00593, 1'b0, 1'b0, 32'h0, p);
    step(1'b1, 32'h00B00613, 1'b1, 1'b1, 32'h400, p);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, p);
    check("d32_occ", seen_occ, 32'd0);
    check("d32_valid", 32'(seen_valid), 32'd0);
    step(1'b1, 32'h00A00593, 1'b0, 1'b0, 32'h0, p);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);
    check("d32_pc", seen_pc, 32'h400);

    // Illegal compressed halfwords advance the PC by 2
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, p);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, p);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);
    check("d33_ill", 32'(seen_ill), 32'd1);
    check("d33_c", 32'(seen_c), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, p);
    check("d33_pc", seen_pc, 32'h302);

    // Random phase
    gen.delete(); gen_skip = 1'b0; have_word = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, p);
    cur_word = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!have_word) begin build_word(cur_word); have_word = 1'b1; end
      if ($urandom_range(0, 599) == 0) begin
        do_reset(2);
        gen.delete(); gen_skip = 1'b0; have_word = 1'b0;
        continue;
      end
      fl  = ($urandom_range(0, 79) == 0);
      fa  = $urandom & 32'h0000_FFFF;
      fv  = ($urandom_range(0, 3) != 0);
      rdy = (n % 200 < 60) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      step(fv, cur_word, rdy, fl, fa, p);
      if (fl) begin
        gen.delete(); gen_skip = fa[1]; have_word = 1'b0;
      end else if (p) begin
        have_word = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
